id_issue_queue: RTL and testbench

ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

---
 rtl/config_pkg.sv | 10 +
 rtl/id_issue_queue_pkg.sv | 28 ++
 rtl/id_issue_queue_checker.sv | 34 +++
 rtl/id_issue_queue.sv | 101 ++++++++++
 tb/tb_id_issue_queue.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Core configuration subset consumed by the ID stage.
package config_pkg;

   typedef struct packed {
      int unsigned NrIssuePorts;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{NrIssuePorts: 32'd1};

endpackage

// File: rtl/id_issue_queue_pkg.sv
// Helper arithmetic for the ID issue queue: popcount and modulo-Depth pointer add.
package id_issue_queue_pkg;

   localparam int unsigned MaxDepth = 32'd8;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   // Operands are below 2*MaxDepth, so one conditional subtract gives the modulo.
   function automatic logic [4:0] wrap_add(input logic [4:0] a, input logic [4:0] b,
                                           input logic [4:0] depth);
      logic [4:0] s;
      s = a + b;
      if (s >= depth) begin
         s = s - depth;
      end else begin
         s = s;
      end
      return s;
   endfunction

endpackage

// File: rtl/id_issue_queue_checker.sv
// Protocol checker for the issue acks: acks must be a contiguous prefix of valid ports.
module id_issue_queue_checker #(
   parameter int unsigned NrIssuePorts = 32'd1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    en_i,
   input  logic [NrIssuePorts-1:0] valid_i,
   input  logic [NrIssuePorts-1:0] ack_i,
   output logic                    proto_err_o
);

   // Flag any ack on an invalid port or with a gap below it.
   always_comb begin
      proto_err_o = 1'b0;
      for (int k = 0; k < NrIssuePorts; k++) begin
         if (ack_i[k] && !valid_i[k]) begin
            proto_err_o = 1'b1;
         end else begin
            proto_err_o = proto_err_o;
         end
      end
      for (int k = 1; k < NrIssuePorts; k++) begin
         if (ack_i[k] && !ack_i[k-1]) begin
            proto_err_o = 1'b1;
         end else begin
            proto_err_o = proto_err_o;
         end
      end
   end

   a_ack_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni || !en_i) !proto_err_o);

endmodule

// File: rtl/id_issue_queue.sv
// ID/issue queue: circular buffer of decoded instructions replacing the single
// ID pipeline register; issues up to NrIssuePorts entries from the head in order.
module id_issue_queue
   import id_issue_queue_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   parameter type scoreboard_entry_t = logic,
   parameter int unsigned Depth = (CVA6Cfg.NrIssuePorts > 32'd0) ? CVA6Cfg.NrIssuePorts : 32'd1,
   parameter int unsigned NrIssuePorts = (CVA6Cfg.NrIssuePorts > 32'd0) ? CVA6Cfg.NrIssuePorts : 32'd1
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_i,
   input  logic                               dec_valid_i,
   input  scoreboard_entry_t                  dec_entry_i,
   input  logic [31:0]                        dec_orig_instr_i,
   input  logic                               dec_is_ctrl_flow_i,
   input  logic                               dec_hold_i,
   output logic                               dec_accept_o,
   output logic                               fetch_entry_ready_o,
   output scoreboard_entry_t [NrIssuePorts-1:0] issue_entry_o,
   output logic [NrIssuePorts-1:0][31:0]      orig_instr_o,
   output logic [NrIssuePorts-1:0]            is_ctrl_flow_o,
   output logic [NrIssuePorts-1:0]            issue_entry_valid_o,
   input  logic [NrIssuePorts-1:0]            issue_instr_ack_i,
   output logic [$clog2(Depth+1)-1:0]         occupancy_o
);

   localparam int unsigned PtrW = (Depth > 32'd1) ? $clog2(Depth) : 32'd1;
   localparam int unsigned CntW = $clog2(Depth + 32'd1);

   typedef struct packed {
      scoreboard_entry_t sbe;
      logic [31:0]       orig_instr;
      logic              is_ctrl_flow;
   } entry_t;

   entry_t            mem_r [Depth];
   logic [PtrW-1:0]   rd_ptr_r;
   logic [PtrW-1:0]   wr_ptr_r;
   logic [CntW-1:0]   count_r;

   logic [NrIssuePorts-1:0] valid_s;
   logic [NrIssuePorts-1:0] ack_eff_s;
   logic [3:0]              pops_s;
   logic [4:0]              used_s;
   logic                    push_s;
   logic [PtrW-1:0]         port_ptr_s;

   // Head window, pop count and push decision; acks on empty ports are ignored.
   always_comb begin
      valid_s        = '0;
      issue_entry_o  = '0;
      orig_instr_o   = '0;
      is_ctrl_flow_o = '0;
      port_ptr_s     = '0;
      for (int k = 0; k < NrIssuePorts; k++) begin
         valid_s[k]        = (5'(count_r) > 5'(k));
         port_ptr_s        = PtrW'(wrap_add(5'(rd_ptr_r), 5'(k), 5'(Depth)));
         issue_entry_o[k]  = mem_r[port_ptr_s].sbe;
         orig_instr_o[k]   = mem_r[port_ptr_s].orig_instr;
         is_ctrl_flow_o[k] = mem_r[port_ptr_s].is_ctrl_flow;
      end
      ack_eff_s = issue_instr_ack_i & valid_s;
      pops_s    = popcount8(8'(ack_eff_s));
      used_s    = 5'(count_r) - {1'b0, pops_s};
      push_s    = rst_ni & dec_valid_i & ~flush_i & (used_s < 5'(Depth));
   end

   assign issue_entry_valid_o = valid_s;
   assign occupancy_o         = count_r;
   assign dec_accept_o        = push_s;
   assign fetch_entry_ready_o = push_s & ~dec_hold_i;

   // Pointer, count and storage update; flush discards same-cycle push and pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush_i) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         rd_ptr_r <= PtrW'(wrap_add(5'(rd_ptr_r), {1'b0, pops_s}, 5'(Depth)));
         count_r  <= CntW'(used_s + {4'd0, push_s});
         if (push_s) begin
            mem_r[wr_ptr_r] <= '{sbe: dec_entry_i, orig_instr: dec_orig_instr_i,
                                 is_ctrl_flow: dec_is_ctrl_flow_i};
            wr_ptr_r        <= PtrW'(wrap_add(5'(wr_ptr_r), 5'd1, 5'(Depth)));
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
      end
   end

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue at Depth/ports 4/2, 1/1 and 3/1.
module tb_id_issue_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, dec_valid, hold, ctrl, chk_en;
   logic [7:0]  dec_entry;
   logic [31:0] orig_in;

   // Depth 4, two ports
   logic              acc4, rdy4, err4;
   logic [1:0][7:0]   ent4;
   logic [1:0][31:0]  orig4;
   logic [1:0]        cf4, val4, ack4;
   logic [2:0]        occ4;
   // Depth 1, one port
   logic              acc1, rdy1, err1;
   logic [0:0][7:0]   ent1;
   logic [0:0][31:0]  orig1;
   logic [0:0]        cf1, val1, ack1;
   logic [0:0]        occ1;
   // Depth 3, one port
   logic              acc3, rdy3, err3;
   logic [0:0][7:0]   ent3;
   logic [0:0][31:0]  orig3;
   logic [0:0]        cf3, val3, ack3;
   logic [1:0]        occ3;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   id_issue_queue #(.scoreboard_entry_t(logic [7:0]), .Depth(4), .NrIssuePorts(2)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .dec_valid_i(dec_valid),
      .dec_entry_i(dec_entry), .dec_orig_instr_i(orig_in), .dec_is_ctrl_flow_i(ctrl),
      .dec_hold_i(hold), .dec_accept_o(acc4), .fetch_entry_ready_o(rdy4),
      .issue_entry_o(ent4), .orig_instr_o(orig4), .is_ctrl_flow_o(cf4),
      .issue_entry_valid_o(val4), .issue_instr_ack_i(ack4), .occupancy_o(occ4));

   id_issue_queue #(.scoreboard_entry_t(logic [7:0]), .Depth(1), .NrIssuePorts(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .dec_valid_i(dec_valid),
      .dec_entry_i(dec_entry), .dec_orig_instr_i(orig_in), .dec_is_ctrl_flow_i(ctrl),
      .dec_hold_i(hold), .dec_accept_o(acc1), .fetch_entry_ready_o(rdy1),
      .issue_entry_o(ent1), .orig_instr_o(orig1), .is_ctrl_flow_o(cf1),
      .issue_entry_valid_o(val1), .issue_instr_ack_i(ack1), .occupancy_o(occ1));

   id_issue_queue #(.scoreboard_entry_t(logic [7:0]), .Depth(3), .NrIssuePorts(1)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .dec_valid_i(dec_valid),
      .dec_entry_i(dec_entry), .dec_orig_instr_i(orig_in), .dec_is_ctrl_flow_i(ctrl),
      .dec_hold_i(hold), .dec_accept_o(acc3), .fetch_entry_ready_o(rdy3),
      .issue_entry_o(ent3), .orig_instr_o(orig3), .is_ctrl_flow_o(cf3),
      .issue_entry_valid_o(val3), .issue_instr_ack_i(ack3), .occupancy_o(occ3));

   id_issue_queue_checker #(.NrIssuePorts(2)) chk4 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(chk_en), .valid_i(val4), .ack_i(ack4),
      .proto_err_o(err4));
   id_issue_queue_checker #(.NrIssuePorts(1)) chk1 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(1'b1), .valid_i(val1), .ack_i(ack1),
      .proto_err_o(err1));
   id_issue_queue_checker #(.NrIssuePorts(1)) chk3 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(1'b1), .valid_i(val3), .ack_i(ack3),
      .proto_err_o(err3));

   typedef struct {
      logic       v;
      logic [7:0] n;
      logic       h;
      logic       f;
      logic [1:0] ack;
      logic       e_acc;
      logic       e_rdy;
      logic [2:0] e_occ;
      logic [1:0] e_val;
      logic [7:0] e_p0;
      logic [7:0] e_p1;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   // Entry n carries sbe n^5A, instruction 0x1000_0000+n and ctrl flag n[0].
   task automatic drive(input logic [7:0] n);
      dec_entry = n ^ 8'h5A;
      orig_in   = 32'h1000_0000 + 32'(n);
      ctrl      = n[0];
   endtask

   task automatic flush_cycle();
      flush     = 1'b1;
      dec_valid = 1'b0;
      ack4 = 2'b00; ack1 = 1'b0; ack3 = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   initial begin
      //           v     n      h     f     ack    acc   rdy   occ   val    p0     p1
      vecs[0]  = '{1'b1, 8'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd1, 2'b01, 8'd0, 8'd0};
      vecs[1]  = '{1'b1, 8'd1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd2, 2'b11, 8'd0, 8'd1};
      vecs[2]  = '{1'b1, 8'd2, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd3, 2'b11, 8'd0, 8'd1};
      vecs[3]  = '{1'b1, 8'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd4, 2'b11, 8'd0, 8'd1};
      vecs[4]  = '{1'b1, 8'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd4, 2'b11, 8'd0, 8'd1};
      vecs[5]  = '{1'b1, 8'd4, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 3'd3, 2'b11, 8'd2, 8'd3};
      vecs[6]  = '{1'b1, 8'd5, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 2'b00, 8'd0, 8'd0};
      vecs[7]  = '{1'b1, 8'd6, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'd1, 2'b01, 8'd6, 8'd0};
      vecs[8]  = '{1'b1, 8'd7, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'd2, 2'b11, 8'd6, 8'd7};
      vecs[9]  = '{1'b1, 8'd8, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 3'd3, 2'b11, 8'd6, 8'd7};
      vecs[10] = '{1'b0, 8'd9, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 3'd2, 2'b11, 8'd7, 8'd8};
      vecs[11] = '{1'b0, 8'd9, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 2'b00, 8'd0, 8'd0};

      rst_n = 1'b0; flush = 1'b0; dec_valid = 1'b1; hold = 1'b0; chk_en = 1'b1;
      ack4 = 2'b00; ack1 = 1'b0; ack3 = 1'b0;
      drive(8'hFF);
      #2;
      chk("reset_valid", 32'(val4), 32'd0);
      chk("reset_occ", 32'(occ4), 32'd0);
      chk("reset_accept", 32'(acc4), 32'd0);
      chk("reset_ready", 32'(rdy4), 32'd0);
      #10 rst_n = 1'b1;
      dec_valid = 1'b0;
      @(posedge clk); #1;

      // Depth 4 / 2 ports: fill, full stall, ack-with-push, flush, hold handshake
      for (int i = 0; i < 12; i++) begin
         dec_valid = vecs[i].v; hold = vecs[i].h; flush = vecs[i].f; ack4 = vecs[i].ack;
         drive(vecs[i].n);
         #1;
         chk($sformatf("d4_accept[%0d]", i), 32'(acc4), 32'(vecs[i].e_acc));
         chk($sformatf("d4_ready[%0d]", i), 32'(rdy4), 32'(vecs[i].e_rdy));
         chk($sformatf("d4_proto[%0d]", i), 32'(err4), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("d4_occ[%0d]", i), 32'(occ4), 32'(vecs[i].e_occ));
         chk($sformatf("d4_valid[%0d]", i), 32'(val4), 32'(vecs[i].e_val));
         if (vecs[i].e_val[0]) begin
            chk($sformatf("d4_p0_instr[%0d]", i), orig4[0], 32'h1000_0000 + 32'(vecs[i].e_p0));
            chk($sformatf("d4_p0_sbe[%0d]", i), 32'(ent4[0]), 32'(vecs[i].e_p0 ^ 8'h5A));
            chk($sformatf("d4_p0_cf[%0d]", i), 32'(cf4[0]), 32'(vecs[i].e_p0[0]));
         end else begin
            chk($sformatf("d4_p1_invalid[%0d]", i), 32'(val4[1]), 32'd0);
         end
         if (vecs[i].e_val[1]) begin
            chk($sformatf("d4_p1_instr[%0d]", i), orig4[1], 32'h1000_0000 + 32'(vecs[i].e_p1));
         end else begin
            chk($sformatf("d4_p1_clear[%0d]", i), 32'(val4[1]), 32'd0);
         end
      end
      hold = 1'b0; ack4 = 2'b00;

      // Depth 1: one entry per cycle with ready held high
      flush_cycle();
      for (int i = 0; i < 6; i++) begin
         dec_valid = 1'b1;
         drive(8'h20 + 8'(i));
         ack1 = val1;
         #1;
         chk($sformatf("d1_ready[%0d]", i), 32'(rdy1), 32'd1);
         chk($sformatf("d1_accept[%0d]", i), 32'(acc1), 32'd1);
         chk($sformatf("d1_proto[%0d]", i), 32'(err1), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("d1_valid[%0d]", i), 32'(val1), 32'd1);
         chk($sformatf("d1_instr[%0d]", i), orig1[0], 32'h1000_0020 + 32'(i));
      end
      dec_valid = 1'b0; ack1 = 1'b0;

      // Depth 3: ten pushes with continuous ack, pointers wrap every third entry
      flush_cycle();
      for (int i = 0; i < 10; i++) begin
         dec_valid = 1'b1;
         drive(8'h30 + 8'(i));
         ack3 = val3;
         #1;
         chk($sformatf("d3_accept[%0d]", i), 32'(acc3), 32'd1);
         chk($sformatf("d3_proto[%0d]", i), 32'(err3), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("d3_occ[%0d]", i), 32'(occ3), 32'd1);
         chk($sformatf("d3_instr[%0d]", i), orig3[0], 32'h1000_0030 + 32'(i));
      end
      dec_valid = 1'b0; ack3 = 1'b0;

      // Mid-operation reset drops held entries; stray ack afterwards is a protocol error
      flush_cycle();
      for (int i = 0; i < 2; i++) begin
         dec_valid = 1'b1;
         drive(8'h40 + 8'(i));
         @(posedge clk); #1;
      end
      chk("rst_pre_occ", 32'(occ4), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(val4), 32'd0);
      chk("rst_mid_occ", 32'(occ4), 32'd0);
      chk("rst_mid_accept", 32'(acc4), 32'd0);
      chk("rst_mid_ready", 32'(rdy4), 32'd0);
      @(posedge clk); #3;
      dec_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_post_occ", 32'(occ4), 32'd0);
      chk("rst_post_valid", 32'(val4), 32'd0);
      chk_en = 1'b0;
      ack4 = 2'b10;
      #1;
      chk("stray_ack_flag", 32'(err4), 32'd1);
      @(posedge clk); #1;
      chk("stray_ack_occ", 32'(occ4), 32'd0);
      ack4 = 2'b00;
      #1;
      chk_en = 1'b1;
      chk("legal_ack_flag", 32'(err4), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
